ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage pipeline; the consumer of the ID/EX register outputs. Resolves operands through MEM/WB forwarding, runs the ALU, resolves jumps and branches, and registers results into the EX/MEM boundary. Includes an iterative 8-cycle multiplier that stalls the front end while it runs.

## Interface
- No parameters.

**Clock, reset and ID/EX inputs**
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_pc  in  5  instruction word index
- in_rs1 / in_rs2  in  5 each  source register numbers
- in_rd1 / in_rd2  in  32 each  register file read data
- in_imm  in  32  sign-extended immediate
- in_alu_src  in  1  1: ALU operand B = in_imm, 0: forwarded rs2
- in_alu_op  in  5  operation code (below)
- in_is_jump  in  1  jump-and-link
- in_reg_wrenable, in_mem_wrenable, in_mem_to_reg  in  1 each  control passthrough
- in_write_reg  in  5  destination register

**Forwarding inputs**
- mem_fwd_en  in  1  EX/MEM instruction writes a register
- mem_fwd_reg  in  5  its destination
- mem_fwd_data  in  32  its ALU result
- wb_fwd_en  in  1  MEM/WB instruction writes a register
- wb_fwd_reg  in  5  its destination
- wb_fwd_data  in  32  its writeback value

**Outputs**
- stall  out  1  combinational; hold PC, IF/ID and ID/EX
- out_alu_result  out  32  registered result
- out_store_data  out  32  forwarded rs2 value
- out_write_reg  out  5  destination register
- out_reg_wrenable, out_mem_wrenable, out_mem_to_reg  out  1 each  control
- out_taken  out  1  redirect PC
- out_target  out  5  redirect index

## Operation
- Forwarding, per source: register 0 is never forwarded. Use MEM if mem_fwd_en and mem_fwd_reg==rs; else WB if wb_fwd_en and wb_fwd_reg==rs; else rd. MEM wins when both match.
- A = fwd rs1. B = in_imm if in_alu_src, else fwd rs2.
- alu_op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift amount B[4:0])
  - 8 SLT (signed), 9 SLTU, 10 PASSB
  - 11 MUL (low 32 bits of the product)
  - 12 BEQ, 13 BNE (result 0, taken if A==B / A!=B, target = in_pc+in_imm[4:0] mod 32)
  - 14–31: result 0
- in_is_jump overrides alu_op: result = in_pc+1 (5-bit wrap, zero-extended); taken=1; target = (A+in_imm)[4:0].
- Arithmetic is 32-bit, modulo 2^32; overflow is ignored.

**Multiplier FSM**, states IDLE and BUSY, with a 3-bit count:
- IDLE with alu_op==11 and not is_jump:
  - capture multiplicand=A, multiplier=B; acc=0, count=0
  - go to BUSY
  - stall=1
- BUSY, each cycle:
  - acc += (multiplicand << 4*count) × multiplier nibble[count]
  - count++
- stall = (IDLE & MUL) | (BUSY & count!=7).
- At BUSY with count==7: stall=0; EX/MEM captures the final acc and the passthrough controls; next state IDLE.
- While stall=1, EX/MEM loads a bubble: reg_wrenable=0, mem_wrenable=0, mem_to_reg=0, taken=0. Data fields are don't-care.

## Timing
- Reset (asynchronous): every registered output is 0, state=IDLE, count=0. Consequently stall=0 unless MUL is presented.
- Non-MUL instructions: one-cycle latency. Inputs at edge N appear on outputs after edge N+1.
- MUL: 9 cycles of occupancy (1 IDLE + 8 BUSY); the result is valid after the 9th edge.
  - Operands are latched at entry, so forwarding changes during BUSY do not affect the result.
  - Upstream holds ID/EX stable while stall=1.
- Reset asserted in BUSY: abort immediately; no writeback is produced.
- A MUL directly following a MUL: re-enters BUSY from IDLE on the cycle after completion; there is no overlap.

## Test plan
- Reset mid-operation: rst pulse during BUSY → all outputs 0, stall=0, IDLE; the following ADD completes in 1 cycle.
- ALU and forwarding: ADD with rd1=5, rd2=7, alu_src=0, rs2=3; MEM forwarding r3=100 and WB r3=200 both active → out_alu_result=105. With rs2=0 and a forward targeting r0 → forward ignored, result 12.
- SRA and SLT: SRA A=0x80000000, imm=4, alu_src=1 → 0xF8000000. SLT A=-1, B=1 → 1; SLTU with the same operands → 0.
- MUL 0x12345678×0x10 → stall high for exactly 8 cycles; writeback after the 9th edge with 0x23456780; 8 bubbles precede it, each with reg_wrenable=0.
- Jump and branches:
  - JAL at pc=31, rd1=4, imm=3 → result 0, taken=1, target 7
  - BEQ with A==B, pc=30, imm=5 → taken=1, target 3
  - BNE with A==B → taken=0

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, jump/branch resolution and the EX/MEM register,
// plus an 8-step nibble-serial multiplier that stalls the front end while it runs.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  in_pc,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_rd1,
    input  logic [31:0] in_rd2,
    input  logic [31:0] in_imm,
    input  logic        in_alu_src,
    input  logic [4:0]  in_alu_op,
    input  logic        in_is_jump,
    input  logic        in_reg_wrenable,
    input  logic        in_mem_wrenable,
    input  logic        in_mem_to_reg,
    input  logic [4:0]  in_write_reg,
    input  logic        mem_fwd_en,
    input  logic [4:0]  mem_fwd_reg,
    input  logic [31:0] mem_fwd_data,
    input  logic        wb_fwd_en,
    input  logic [4:0]  wb_fwd_reg,
    input  logic [31:0] wb_fwd_data,
    output logic        stall,
    output logic [31:0] out_alu_result,
    output logic [31:0] out_store_data,
    output logic [4:0]  out_write_reg,
    output logic        out_reg_wrenable,
    output logic        out_mem_wrenable,
    output logic        out_mem_to_reg,
    output logic        out_taken,
    output logic [4:0]  out_target
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

    mul_state_t  state_r;
    logic [2:0]  count_r;
    logic [31:0] mcand_r;
    logic [31:0] mplier_r;
    logic [31:0] acc_r;

    logic [31:0] op_a_s;
    logic [31:0] op_b_s;
    logic [31:0] rs2_val_s;
    logic [3:0]  nibble_s;
    logic [31:0] partial_s;
    logic [31:0] acc_next_s;
    logic [31:0] alu_result_s;
    logic        taken_s;
    logic [4:0]  target_s;
    logic        mul_req_s;
    logic        mul_done_s;

    // The youngest producer (EX/MEM) wins; r0 is hard-wired and never forwarded.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  rs,
        input logic [31:0] rd,
        input logic        m_en,
        input logic [4:0]  m_reg,
        input logic [31:0] m_data,
        input logic        w_en,
        input logic [4:0]  w_reg,
        input logic [31:0] w_data
    );
        logic [31:0] val;
        if (rs == 5'd0) begin
            val = rd;
        end else if (m_en && (m_reg == rs)) begin
            val = m_data;
        end else if (w_en && (w_reg == rs)) begin
            val = w_data;
        end else begin
            val = rd;
        end
        return val;
    endfunction

    assign mul_req_s  = (in_alu_op == 5'd11) && !in_is_jump;
    assign mul_done_s = (state_r == BUSY) && (count_r == 3'd7);
    assign stall      = ((state_r == IDLE) && mul_req_s) || ((state_r == BUSY) && (count_r != 3'd7));

    // Resolve both source operands through the forwarding network.
    always_comb begin
        op_a_s    = fwd_sel(in_rs1, in_rd1, mem_fwd_en, mem_fwd_reg, mem_fwd_data,
                            wb_fwd_en, wb_fwd_reg, wb_fwd_data);
        rs2_val_s = fwd_sel(in_rs2, in_rd2, mem_fwd_en, mem_fwd_reg, mem_fwd_data,
                            wb_fwd_en, wb_fwd_reg, wb_fwd_data);
        if (in_alu_src) begin
            op_b_s = in_imm;
        end else begin
            op_b_s = rs2_val_s;
        end
    end

    // One multiplier step: shifted multiplicand times the current multiplier nibble.
    always_comb begin
        nibble_s   = mplier_r[{count_r, 2'b00} +: 4];
        partial_s  = (mcand_r << {count_r, 2'b00}) * {28'd0, nibble_s};
        acc_next_s = acc_r + partial_s;
    end

    // ALU and control-flow resolution; a jump overrides whatever alu_op says.
    always_comb begin
        alu_result_s = 32'd0;
        taken_s      = 1'b0;
        target_s     = 5'd0;
        if (in_is_jump) begin
            alu_result_s = {27'd0, in_pc + 5'd1};
            taken_s      = 1'b1;
            target_s     = op_a_s[4:0] + in_imm[4:0];
        end else begin
            case (in_alu_op)
                5'd0:  alu_result_s = op_a_s + op_b_s;
                5'd1:  alu_result_s = op_a_s - op_b_s;
                5'd2:  alu_result_s = op_a_s & op_b_s;
                5'd3:  alu_result_s = op_a_s | op_b_s;
                5'd4:  alu_result_s = op_a_s ^ op_b_s;
                5'd5:  alu_result_s = op_a_s << op_b_s[4:0];
                5'd6:  alu_result_s = op_a_s >> op_b_s[4:0];
                5'd7:  alu_result_s = $signed(op_a_s) >>> op_b_s[4:0];
                5'd8:  alu_result_s = {31'd0, $signed(op_a_s) < $signed(op_b_s)};
                5'd9:  alu_result_s = {31'd0, op_a_s < op_b_s};
                5'd10: alu_result_s = op_b_s;
                5'd11: alu_result_s = acc_next_s;
                5'd12: begin
                    taken_s  = (op_a_s == op_b_s);
                    target_s = in_pc + in_imm[4:0];
                end
                5'd13: begin
                    taken_s  = (op_a_s != op_b_s);
                    target_s = in_pc + in_imm[4:0];
                end
                default: alu_result_s = 32'd0;
            endcase
        end
    end

    // Multiplier FSM; operands are latched on entry so later forwarding cannot disturb them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            count_r  <= 3'd0;
            mcand_r  <= 32'd0;
            mplier_r <= 32'd0;
            acc_r    <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mul_req_s) begin
                        mcand_r  <= op_a_s;
                        mplier_r <= op_b_s;
                        acc_r    <= 32'd0;
                        count_r  <= 3'd0;
                        state_r  <= BUSY;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                BUSY: begin
                    acc_r   <= acc_next_s;
                    count_r <= count_r + 3'd1;
                    if (mul_done_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    count_r <= 3'd0;
                end
            endcase
        end
    end

    // EX/MEM boundary register; a stall inserts a bubble and leaves the data fields as they were.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_alu_result   <= 32'd0;
            out_store_data   <= 32'd0;
            out_write_reg    <= 5'd0;
            out_reg_wrenable <= 1'b0;
            out_mem_wrenable <= 1'b0;
            out_mem_to_reg   <= 1'b0;
            out_taken        <= 1'b0;
            out_target       <= 5'd0;
        end else if (stall) begin
            out_reg_wrenable <= 1'b0;
            out_mem_wrenable <= 1'b0;
            out_mem_to_reg   <= 1'b0;
            out_taken        <= 1'b0;
        end else begin
            out_alu_result   <= alu_result_s;
            out_store_data   <= rs2_val_s;
            out_write_reg    <= in_write_reg;
            out_reg_wrenable <= in_reg_wrenable;
            out_mem_wrenable <= in_mem_wrenable;
            out_mem_to_reg   <= in_mem_to_reg;
            out_taken        <= taken_s;
            out_target       <= target_s;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver pushes one expected record per cycle,
// a negedge monitor checks stall for that cycle and the registered outputs one edge later.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  in_pc, in_rs1, in_rs2, in_alu_op, in_write_reg;
    logic [31:0] in_rd1, in_rd2, in_imm;
    logic        in_alu_src, in_is_jump, in_reg_wrenable, in_mem_wrenable, in_mem_to_reg;
    logic        mem_fwd_en, wb_fwd_en;
    logic [4:0]  mem_fwd_reg, wb_fwd_reg;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        stall;
    logic [31:0] out_alu_result, out_store_data;
    logic [4:0]  out_write_reg, out_target;
    logic        out_reg_wrenable, out_mem_wrenable, out_mem_to_reg, out_taken;

    ex_stage dut (
        .clk(clk), .rst(rst),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd1(in_rd1), .in_rd2(in_rd2),
        .in_imm(in_imm), .in_alu_src(in_alu_src), .in_alu_op(in_alu_op), .in_is_jump(in_is_jump),
        .in_reg_wrenable(in_reg_wrenable), .in_mem_wrenable(in_mem_wrenable),
        .in_mem_to_reg(in_mem_to_reg), .in_write_reg(in_write_reg),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_reg(mem_fwd_reg), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_reg(wb_fwd_reg), .wb_fwd_data(wb_fwd_data),
        .stall(stall), .out_alu_result(out_alu_result), .out_store_data(out_store_data),
        .out_write_reg(out_write_reg), .out_reg_wrenable(out_reg_wrenable),
        .out_mem_wrenable(out_mem_wrenable), .out_mem_to_reg(out_mem_to_reg),
        .out_taken(out_taken), .out_target(out_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  pc, rs1, rs2, wreg, op, mreg, wbreg;
        logic [31:0] rd1, rd2, imm, mdata, wdata;
        logic        src, jump, rwe, mwe, m2r, men, wen;
    } instr_t;

    typedef struct {
        bit          stall;
        bit          data;
        logic [31:0] result, store;
        logic [4:0]  wreg, target;
        bit          rwe, mwe, m2r, taken;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    bit   have_pend = 1'b0;
    exp_t pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] fwdv(input logic [4:0] rs, input logic [31:0] rd);
        if (rs == 5'd0) return rd;
        if (mem_fwd_en && mem_fwd_reg == rs) return mem_fwd_data;
        if (wb_fwd_en && wb_fwd_reg == rs) return wb_fwd_data;
        return rd;
    endfunction

    // Reference model: what the EX/MEM register should hold for the instruction now presented.
    function automatic exp_t model(input logic [31:0] mul_a, input logic [31:0] mul_b);
        exp_t e;
        logic [31:0] a, b;
        a = fwdv(in_rs1, in_rd1);
        e.store = fwdv(in_rs2, in_rd2);
        b = in_alu_src ? in_imm : e.store;
        e.stall = 1'b0; e.data = 1'b1; e.wreg = in_write_reg;
        e.rwe = in_reg_wrenable; e.mwe = in_mem_wrenable; e.m2r = in_mem_to_reg;
        e.taken = 1'b0; e.target = 5'd0; e.result = 32'd0;
        if (in_is_jump) begin
            e.result = 32'(5'(in_pc + 5'd1));
            e.taken  = 1'b1;
            e.target = 5'(a + in_imm);
        end else begin
            case (in_alu_op)
                5'd0:  e.result = a + b;
                5'd1:  e.result = a - b;
                5'd2:  e.result = a & b;
                5'd3:  e.result = a | b;
                5'd4:  e.result = a ^ b;
                5'd5:  e.result = a << b[4:0];
                5'd6:  e.result = a >> b[4:0];
                5'd7:  e.result = 32'($signed(a) >>> b[4:0]);
                5'd8:  e.result = 32'($signed(a) < $signed(b));
                5'd9:  e.result = 32'(a < b);
                5'd10: e.result = b;
                5'd11: e.result = mul_a * mul_b;
                5'd12: begin e.taken = (a == b); e.target = 5'(in_pc + in_imm[4:0]); end
                5'd13: begin e.taken = (a != b); e.target = 5'(in_pc + in_imm[4:0]); end
                default: e.result = 32'd0;
            endcase
        end
        return e;
    endfunction

    task automatic apply(input instr_t t);
        in_pc = t.pc; in_rs1 = t.rs1; in_rs2 = t.rs2; in_rd1 = t.rd1; in_rd2 = t.rd2;
        in_imm = t.imm; in_alu_src = t.src; in_alu_op = t.op; in_is_jump = t.jump;
        in_reg_wrenable = t.rwe; in_mem_wrenable = t.mwe; in_mem_to_reg = t.m2r;
        in_write_reg = t.wreg;
        mem_fwd_en = t.men; mem_fwd_reg = t.mreg; mem_fwd_data = t.mdata;
        wb_fwd_en = t.wen; wb_fwd_reg = t.wbreg; wb_fwd_data = t.wdata;
    endtask

    function automatic instr_t nop();
        instr_t t;
        t.pc = 5'd0; t.rs1 = 5'd0; t.rs2 = 5'd0; t.wreg = 5'd0; t.op = 5'd0;
        t.mreg = 5'd0; t.wbreg = 5'd0; t.rd1 = 32'd0; t.rd2 = 32'd0; t.imm = 32'd0;
        t.mdata = 32'd0; t.wdata = 32'd0; t.src = 1'b0; t.jump = 1'b0; t.rwe = 1'b0;
        t.mwe = 1'b0; t.m2r = 1'b0; t.men = 1'b0; t.wen = 1'b0;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int r;
        t.pc = 5'($urandom); t.rs1 = 5'($urandom_range(0, 3)); t.rs2 = 5'($urandom_range(0, 3));
        t.wreg = 5'($urandom); t.rd1 = $urandom;
        t.rd2 = ($urandom_range(0, 3) == 0) ? t.rd1 : $urandom;
        t.imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
        t.src = 1'($urandom); t.jump = ($urandom_range(0, 9) == 0);
        r = $urandom_range(0, 15);
        t.op = (r < 14) ? 5'(r) : 5'($urandom_range(14, 31));
        t.rwe = 1'($urandom); t.mwe = 1'($urandom); t.m2r = 1'($urandom);
        t.men = 1'($urandom); t.mreg = 5'($urandom_range(0, 3)); t.mdata = $urandom;
        t.wen = 1'($urandom); t.wbreg = 5'($urandom_range(0, 3)); t.wdata = $urandom;
        return t;
    endfunction

    // Present one instruction (nine cycles for a MUL) and queue what each cycle must produce.
    task automatic issue(input instr_t t, input bit use_k, input logic [31:0] k);
        exp_t e, bub;
        logic [31:0] ma, mb;
        bub.stall = 1'b1; bub.data = 1'b0; bub.result = 32'd0; bub.store = 32'd0;
        bub.wreg = 5'd0; bub.target = 5'd0; bub.rwe = 1'b0; bub.mwe = 1'b0;
        bub.m2r = 1'b0; bub.taken = 1'b0;
        @(posedge clk); #2;
        apply(t);
        if (t.op == 5'd11 && !t.jump) begin
            ma = fwdv(t.rs1, t.rd1);
            mb = t.src ? t.imm : fwdv(t.rs2, t.rd2);
            q.push_back(bub);
            for (int c = 1; c < 9; c++) begin
                @(posedge clk); #2;
                mem_fwd_data = $urandom;
                wb_fwd_data  = $urandom;
                if (c < 8) begin
                    q.push_back(bub);
                end else begin
                    e = model(ma, mb);
                    if (use_k) e.result = k;
                    q.push_back(e);
                end
            end
        end else begin
            e = model(32'd0, 32'd0);
            if (use_k) e.result = k;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_result"}, out_alu_result, 32'd0);
        chk({tag, "_store"}, out_store_data, 32'd0);
        chk({tag, "_wreg"}, 32'(out_write_reg), 32'd0);
        chk({tag, "_rwe"}, 32'(out_reg_wrenable), 32'd0);
        chk({tag, "_mwe"}, 32'(out_mem_wrenable), 32'd0);
        chk({tag, "_m2r"}, 32'(out_mem_to_reg), 32'd0);
        chk({tag, "_taken"}, 32'(out_taken), 32'd0);
        chk({tag, "_target"}, 32'(out_target), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    // Monitor: stall is checked in the cycle it applies, outputs one edge later.
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                have_pend = 1'b0;
            end else begin
                if (have_pend) begin
                    if (pend.data) begin
                        chk("result", out_alu_result, pend.result);
                        chk("store_data", out_store_data, pend.store);
                        chk("write_reg", 32'(out_write_reg), 32'(pend.wreg));
                    end
                    chk("reg_wrenable", 32'(out_reg_wrenable), 32'(pend.rwe));
                    chk("mem_wrenable", 32'(out_mem_wrenable), 32'(pend.mwe));
                    chk("mem_to_reg", 32'(out_mem_to_reg), 32'(pend.m2r));
                    chk("taken", 32'(out_taken), 32'(pend.taken));
                    if (pend.taken) chk("target", 32'(out_target), 32'(pend.target));
                    have_pend = 1'b0;
                end
                if (q.size() > 0) begin
                    pend = q.pop_front();
                    chk("stall", 32'(stall), 32'(pend.stall));
                    have_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t t;
        rst = 1'b1;
        apply(nop());
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(posedge clk); #2;
        rst = 1'b0;
        mon_en = 1'b1;

        // ADD with both forwards hitting r3: MEM wins
        t = nop(); t.rd1 = 32'd5; t.rd2 = 32'd7; t.rs1 = 5'd1; t.rs2 = 5'd3; t.rwe = 1'b1;
        t.wreg = 5'd9; t.men = 1'b1; t.mreg = 5'd3; t.mdata = 32'd100;
        t.wen = 1'b1; t.wbreg = 5'd3; t.wdata = 32'd200;
        issue(t, 1'b1, 32'd105);
        t.rs2 = 5'd0; t.mreg = 5'd0; t.wbreg = 5'd0;
        issue(t, 1'b1, 32'd12);

        t = nop(); t.rs1 = 5'd2; t.rd1 = 32'h8000_0000; t.imm = 32'd4; t.src = 1'b1; t.op = 5'd7;
        issue(t, 1'b1, 32'hF800_0000);
        t = nop(); t.rs1 = 5'd2; t.rd1 = 32'hFFFF_FFFF; t.imm = 32'd1; t.src = 1'b1; t.op = 5'd8;
        issue(t, 1'b1, 32'd1);
        t.op = 5'd9;
        issue(t, 1'b1, 32'd0);

        t = nop(); t.rs1 = 5'd2; t.rd1 = 32'h1234_5678; t.imm = 32'h10; t.src = 1'b1;
        t.op = 5'd11; t.rwe = 1'b1; t.wreg = 5'd6;
        issue(t, 1'b1, 32'h2345_6780);

        t = nop(); t.pc = 5'd31; t.rs1 = 5'd2; t.rd1 = 32'd4; t.imm = 32'd3; t.jump = 1'b1; t.rwe = 1'b1;
        issue(t, 1'b1, 32'd0);
        t = nop(); t.pc = 5'd30; t.rs1 = 5'd1; t.rs2 = 5'd2; t.rd1 = 32'd9; t.rd2 = 32'd9;
        t.imm = 32'd5; t.op = 5'd12;
        issue(t, 1'b1, 32'd0);
        t.op = 5'd13;
        issue(t, 1'b1, 32'd0);

        // back-to-back MULs
        for (int i = 0; i < 2; i++) begin
            t = rand_instr(); t.op = 5'd11; t.jump = 1'b0;
            issue(t, 1'b0, 32'd0);
        end

        for (int i = 0; i < 300; i++) begin
            issue(rand_instr(), 1'b0, 32'd0);
        end
        issue(nop(), 1'b0, 32'd0);
        drain();

        // reset asserted in the middle of a multiply
        mon_en = 1'b0;
        t = nop(); t.rs1 = 5'd1; t.rd1 = $urandom; t.imm = $urandom; t.src = 1'b1;
        t.op = 5'd11; t.rwe = 1'b1; t.wreg = 5'd5;
        @(posedge clk); #2;
        apply(t);
        repeat (4) @(posedge clk);
        #2;
        chk("busy_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        apply(nop());
        #1;
        chk_all_zero("midreset");
        @(posedge clk); #2;
        rst = 1'b0;
        mon_en = 1'b1;
        t = nop(); t.rs1 = 5'd1; t.rs2 = 5'd2; t.rd1 = 32'd20; t.rd2 = 32'd22;
        t.rwe = 1'b1; t.wreg = 5'd4;
        issue(t, 1'b1, 32'd42);
        issue(nop(), 1'b0, 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
